guess_entry: RTL and testbench

GUESS_ENTRY -- requirements
Module: guess_entry

---
 rtl/guess_entry.sv | 149 ++++++++++++++
 tb/tb_guess_entry.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// Guess entry: debounced-edge shape loading into a 4-slot guess, then a fixed-length grading pulse.
// Optional undo button enabled by defining GUESS_UNDO_EN.
module guess_entry #(
    parameter int NUM_SHAPES      = 6,
    parameter int GRADE_PULSE_LEN = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [2:0]  shapeIn,
    input  logic        loadShape,
    input  logic        submit,
    input  logic        gamePlaying,
    input  logic        clearGuess,
`ifdef GUESS_UNDO_EN
    input  logic        undo,
`endif
    output logic [11:0] Guess,
    output logic [2:0]  shapeCount,
    output logic        guessFull,
    output logic        badShape,
    output logic        GradeIt
);

    localparam int unsigned CNT_W = $clog2(GRADE_PULSE_LEN + 1);

    typedef enum logic [1:0] {ENTRY, FULL, PULSE, COOLDOWN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   pulse_cnt;
    logic               load_s1, load_s2, sub_s1, sub_s2;
    logic               fresh;
    logic               load_edge, sub_edge, shape_ok;

    assign load_edge = load_s1 & ~load_s2;
    assign sub_edge  = sub_s1 & ~sub_s2;
    assign shape_ok  = int'({29'b0, shapeIn}) < NUM_SHAPES;

`ifdef GUESS_UNDO_EN
    logic undo_s1, undo_s2, undo_edge;
    assign undo_edge = undo_s1 & ~undo_s2;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            undo_s1 <= 1'b0;
            undo_s2 <= 1'b0;
        end else begin
            undo_s1 <= undo;
            undo_s2 <= undo_s1;
        end
    end
`else
    logic undo_edge;
    assign undo_edge = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= ENTRY;
            Guess      <= 12'd0;
            shapeCount <= 3'd0;
            guessFull  <= 1'b0;
            badShape   <= 1'b0;
            GradeIt    <= 1'b0;
            pulse_cnt  <= '0;
            fresh      <= 1'b0;
            load_s1    <= 1'b0;
            load_s2    <= 1'b0;
            sub_s1     <= 1'b0;
            sub_s2     <= 1'b0;
        end else begin
            load_s1  <= loadShape;
            load_s2  <= load_s1;
            sub_s1   <= submit;
            sub_s2   <= sub_s1;
            badShape <= 1'b0;
            if (clearGuess) begin
                state      <= ENTRY;
                Guess      <= 12'd0;
                shapeCount <= 3'd0;
                guessFull  <= 1'b0;
                GradeIt    <= 1'b0;
                pulse_cnt  <= '0;
                fresh      <= 1'b0;
            end else if (gamePlaying) begin
                case (state)
                    ENTRY: begin
                        // Undo beats a simultaneous load; the load is dropped.
                        if (undo_edge) begin
                            if (shapeCount != 3'd0) begin
                                for (int i = 0; i < 4; i++)
                                    if (shapeCount == 3'(i + 1)) Guess[3*i +: 3] <= 3'd0;
                                shapeCount <= shapeCount - 3'd1;
                            end
                        end else if (load_edge) begin
                            if (shape_ok) begin
                                // Previous guess stays visible until the first new shape lands.
                                if (fresh) begin
                                    Guess <= {9'd0, shapeIn};
                                    fresh <= 1'b0;
                                end else begin
                                    for (int i = 0; i < 4; i++)
                                        if (shapeCount == 3'(i)) Guess[3*i +: 3] <= shapeIn;
                                end
                                shapeCount <= shapeCount + 3'd1;
                                if (shapeCount == 3'd3) begin
                                    state     <= FULL;
                                    guessFull <= 1'b1;
                                end
                            end else begin
                                badShape <= 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        if (undo_edge) begin
                            Guess[11:9] <= 3'd0;
                            shapeCount  <= 3'd3;
                            guessFull   <= 1'b0;
                            state       <= ENTRY;
                        end else if (sub_edge) begin
                            state     <= PULSE;
                            guessFull <= 1'b0;
                            GradeIt   <= 1'b1;
                            pulse_cnt <= CNT_W'(GRADE_PULSE_LEN - 1);
                        end
                    end
                    PULSE: begin
                        if (pulse_cnt == '0) begin
                            GradeIt <= 1'b0;
                            state   <= COOLDOWN;
                        end else begin
                            pulse_cnt <= pulse_cnt - CNT_W'(1);
                        end
                    end
                    COOLDOWN: begin
                        // Wait for the submit button to be released before new entry.
                        if (!sub_s1) begin
                            state      <= ENTRY;
                            shapeCount <= 3'd0;
                            fresh      <= 1'b1;
                        end
                    end
                    default: state <= ENTRY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_entry.sv
// Self-checking bench for guess_entry: directed scenarios plus random traffic against a slot-array model.
module tb_guess_entry;

    localparam int NSH = 6;
    localparam int PLEN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, loadShape = 1'b0, submit = 1'b0, gamePlaying = 1'b0, clearGuess = 1'b0;
    logic        undo = 1'b0;
    logic [2:0]  shapeIn = 3'd0;
    logic [11:0] Guess;
    logic [2:0]  shapeCount;
    logic        guessFull, badShape, GradeIt;

    guess_entry #(.NUM_SHAPES(NSH), .GRADE_PULSE_LEN(PLEN)) dut (
        .CLOCK_50(clk), .reset(reset), .shapeIn(shapeIn), .loadShape(loadShape),
        .submit(submit), .gamePlaying(gamePlaying), .clearGuess(clearGuess),
`ifdef GUESS_UNDO_EN
        .undo(undo),
`endif
        .Guess(Guess), .shapeCount(shapeCount), .guessFull(guessFull),
        .badShape(badShape), .GradeIt(GradeIt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: four slots, a count and a phase (0 entry, 1 full, 2 grading, 3 waiting for release).
    logic [2:0] slots [4];
    int  m_cnt = 0, ph = 0, left = 0;
    bit  fresh = 0, m_bad = 0;
    bit  lh1 = 0, lh2 = 0, sh1 = 0, sh2 = 0, uh1 = 0, uh2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] m_guess();
        return {slots[3], slots[2], slots[1], slots[0]};
    endfunction

    task automatic model_step();
        bit le, se, ue, s1prev;
        le = lh1 & ~lh2;
        se = sh1 & ~sh2;
        ue = uh1 & ~uh2;
        s1prev = sh1;
        if (reset) begin
            for (int i = 0; i < 4; i++) slots[i] = 3'd0;
            m_cnt = 0; ph = 0; left = 0; fresh = 0; m_bad = 0;
            lh1 = 0; lh2 = 0; sh1 = 0; sh2 = 0; uh1 = 0; uh2 = 0;
            return;
        end
        lh2 = lh1; lh1 = loadShape;
        sh2 = sh1; sh1 = submit;
`ifdef GUESS_UNDO_EN
        uh2 = uh1; uh1 = undo;
`else
        ue = 0;
`endif
        m_bad = 0;
        if (clearGuess) begin
            for (int i = 0; i < 4; i++) slots[i] = 3'd0;
            m_cnt = 0; ph = 0; fresh = 0;
            return;
        end
        if (!gamePlaying) return;
        case (ph)
            0: if (ue) begin
                   if (m_cnt > 0) begin m_cnt--; slots[m_cnt] = 3'd0; end
               end else if (le) begin
                   if (int'(shapeIn) < NSH) begin
                       if (fresh) begin
                           for (int i = 1; i < 4; i++) slots[i] = 3'd0;
                           fresh = 0;
                       end
                       slots[m_cnt] = shapeIn;
                       m_cnt++;
                       if (m_cnt == 4) ph = 1;
                   end else m_bad = 1;
               end
            1: if (ue) begin slots[3] = 3'd0; m_cnt = 3; ph = 0; end
               else if (se) begin ph = 2; left = PLEN; end
            2: begin left--; if (left == 0) ph = 3; end
            default: if (!s1prev) begin ph = 0; m_cnt = 0; fresh = 1; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("guess", 32'(Guess), 32'(m_guess()));
        chk("count", 32'(shapeCount), 32'(m_cnt));
        chk("full", 32'(guessFull), 32'(ph == 1));
        chk("bad_shape", 32'(badShape), 32'(m_bad));
        chk("grade", 32'(GradeIt), 32'(ph == 2));
    endtask

    task automatic press_load(input logic [2:0] s);
        shapeIn = s; loadShape = 1; tick(); tick();
        loadShape = 0; tick(); tick();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) slots[i] = 3'd0;
        @(negedge clk);
        reset = 1; tick(); tick();
        chk("rst_guess", 32'(Guess), 32'h0);
        chk("rst_grade", 32'(GradeIt), 32'h0);
        reset = 0; gamePlaying = 1;

        // Four valid shapes fill the guess.
        press_load(3'd1); press_load(3'd2); press_load(3'd3); press_load(3'd4);
        chk("fill_guess", 32'(Guess), 32'o4321);
        chk("fill_count", 32'(shapeCount), 32'd4);
        chk("fill_full", 32'(guessFull), 32'd1);

        // Held submit: pulse of PLEN cycles, then wait for release.
        submit = 1; n = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (GradeIt) n++; end
        chk("pulse_len", 32'(n), 32'(PLEN));
        chk("cool_count", 32'(shapeCount), 32'd4);
        submit = 0; tick(); tick(); tick();
        chk("back_count", 32'(shapeCount), 32'd0);
        chk("back_guess", 32'(Guess), 32'o4321);

        // First write after a graded guess clears the upper slots.
        press_load(3'd1); press_load(3'd2);
        chk("fresh_guess", 32'(Guess), 32'o0021);
        shapeIn = 3'd7; loadShape = 1; tick(); tick();
        chk("bad_pulse", 32'(badShape), 32'd1);
        chk("bad_count", 32'(shapeCount), 32'd2);
        tick();
        chk("bad_once", 32'(badShape), 32'd0);
        loadShape = 0; tick(); tick();
        submit = 1;
        for (int i = 0; i < 6; i++) begin tick(); chk("no_partial", 32'(GradeIt), 32'd0); end
        submit = 0; tick(); tick();

        // Clear during the second grading cycle truncates the pulse.
        press_load(3'd3); press_load(3'd4);
        submit = 1; n = 0;
        while (!GradeIt && n < 20) begin tick(); n++; end
        chk("grade_rise", 32'(GradeIt), 32'd1);
        tick();
        clearGuess = 1; tick();
        chk("clr_grade", 32'(GradeIt), 32'd0);
        chk("clr_guess", 32'(Guess), 32'd0);
        chk("clr_count", 32'(shapeCount), 32'd0);
        clearGuess = 0; submit = 0; tick(); tick();

        // Reset from FULL.
        press_load(3'd5); press_load(3'd0); press_load(3'd1); press_load(3'd2);
        chk("full_again", 32'(guessFull), 32'd1);
        reset = 1; tick();
        chk("rst_full", 32'({Guess, shapeCount, guessFull, badShape, GradeIt}), 32'd0);
        reset = 0; tick(); tick();

`ifdef GUESS_UNDO_EN
        press_load(3'd5); press_load(3'd5); press_load(3'd5); press_load(3'd5);
        undo = 1; tick(); tick(); undo = 0; tick(); tick();
        chk("undo_count", 32'(shapeCount), 32'd3);
        chk("undo_guess", 32'(Guess), 32'o0555);
        shapeIn = 3'd2; undo = 1; loadShape = 1; tick(); tick();
        undo = 0; loadShape = 0; tick(); tick();
        chk("undo_win_count", 32'(shapeCount), 32'd2);
        chk("undo_win_guess", 32'(Guess), 32'o0055);
`endif

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            shapeIn     = 3'($urandom_range(0, 7));
            loadShape   = ($urandom_range(0, 2) == 0);
            submit      = ($urandom_range(0, 3) == 0);
            undo        = ($urandom_range(0, 9) == 0);
            clearGuess  = ($urandom_range(0, 59) == 0);
            gamePlaying = ($urandom_range(0, 19) != 0);
            reset       = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
